// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite widths, response codes and address-window decode
package axi_lite_pkg;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  typedef logic [1:0] axi_resp_t;
  localparam axi_resp_t AXI_RESP_OKAY = 2'b00;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
  function automatic logic in_window(input logic [AXI_ADDR_W-1:0] addr, base, words);
    return addr >= base && ((addr - base) >> 2) < words;
  endfunction
endpackage

// File: rtl/ram_be_1r1w.sv
// ram_be_1r1w: word RAM with byte-lane write port and registered read port returning old data on collision
module ram_be_1r1w #(
  parameter int MEM_WORDS = 4096,
  parameter INIT_FILE = "",
  parameter int IW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [IW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [MEM_WORDS];
  // byte-masked store and read capture share the edge, so a same-word read sees the pre-write value
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (we_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/axi_lite_ram_slave.sv
// axi_lite_ram_slave: AXI4-Lite responder backing the memory bus with on-chip RAM
module axi_lite_ram_slave
  import axi_lite_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  output logic [1:0]  mem_axi_bresp,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic [1:0]  mem_axi_rresp
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam logic [31:0] WORDS = 32'(MEM_WORDS);
  logic aw_full_q, aw_full_d, w_full_q, w_full_d, bvalid_q, bvalid_d, rvalid_q, rvalid_d, rd_ok_q, rd_ok_d;
  logic [31:0] aw_addr_q, aw_addr_d, w_data_q, w_data_d;
  logic [3:0] w_strb_q, w_strb_d, ram_we;
  axi_resp_t bresp_q, bresp_d, rresp_q, rresp_d;
  logic aw_hs, w_hs, ar_hs, commit, wr_in, rd_in, unused;
  logic [31:0] wr_addr, wr_data, wr_off, rd_off, ram_rdata;
  logic [3:0] wr_strb;
  assign mem_axi_awready = !aw_full_q && !bvalid_q && !reset;
  assign mem_axi_wready = !w_full_q && !bvalid_q && !reset;
  assign mem_axi_arready = !rvalid_q && !reset;
  assign aw_hs = mem_axi_awvalid && mem_axi_awready;
  assign w_hs = mem_axi_wvalid && mem_axi_wready;
  assign ar_hs = mem_axi_arvalid && mem_axi_arready;
  assign wr_addr = aw_full_q ? aw_addr_q : mem_axi_awaddr;
  assign wr_data = w_full_q ? w_data_q : mem_axi_wdata;
  assign wr_strb = w_full_q ? w_strb_q : mem_axi_wstrb;
  assign wr_off = wr_addr - BASE_ADDR;
  assign rd_off = mem_axi_araddr - BASE_ADDR;
  assign wr_in = in_window(wr_addr, BASE_ADDR, WORDS);
  assign rd_in = in_window(mem_axi_araddr, BASE_ADDR, WORDS);
  assign commit = (aw_full_q || aw_hs) && (w_full_q || w_hs) && !bvalid_q;
  assign ram_we = commit && wr_in ? wr_strb : 4'b0000;
  assign mem_axi_bvalid = bvalid_q;
  assign mem_axi_bresp = bresp_q;
  assign mem_axi_rvalid = rvalid_q;
  assign mem_axi_rresp = rresp_q;
  assign mem_axi_rdata = rd_ok_q ? ram_rdata : 32'h0;
  assign unused = ^{mem_axi_awprot, mem_axi_arprot, wr_off, rd_off};
  // next state: holding registers fill on handshake and drain on commit; responses hold until accepted
  always_comb begin
    aw_full_d = commit ? 1'b0 : aw_full_q || aw_hs;
    aw_addr_d = aw_hs ? mem_axi_awaddr : aw_addr_q;
    w_full_d = commit ? 1'b0 : w_full_q || w_hs;
    w_data_d = w_hs ? mem_axi_wdata : w_data_q;
    w_strb_d = w_hs ? mem_axi_wstrb : w_strb_q;
    bvalid_d = commit || (bvalid_q && !mem_axi_bready);
    bresp_d = commit ? (wr_in ? AXI_RESP_OKAY : AXI_RESP_SLVERR) : bresp_q;
    rvalid_d = ar_hs || (rvalid_q && !mem_axi_rready);
    rresp_d = ar_hs ? (rd_in ? AXI_RESP_OKAY : AXI_RESP_SLVERR) : rresp_q;
    rd_ok_d = ar_hs ? rd_in : rd_ok_q;
  end
  // state registers; reset drops any in-flight transaction without a response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q <= AXI_RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q <= AXI_RESP_OKAY;
      rd_ok_q <= 1'b0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q <= w_full_d;
      w_data_q <= w_data_d;
      w_strb_q <= w_strb_d;
      bvalid_q <= bvalid_d;
      bresp_q <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q <= rresp_d;
      rd_ok_q <= rd_ok_d;
    end
  end
  ram_be_1r1w #(.MEM_WORDS(MEM_WORDS), .INIT_FILE(INIT_FILE)) u_ram (
    .clk(clk),
    .we_i(ram_we),
    .waddr_i(wr_off[IW+1:2]),
    .wdata_i(wr_data),
    .re_i(ar_hs),
    .raddr_i(rd_off[IW+1:2]),
    .rdata_o(ram_rdata)
  );
endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// tb_axi_lite_ram_slave: randomized AXI4-Lite traffic checked against an array model of the RAM window
module tb_axi_lite_ram_slave;
  localparam int WORDS = 256;
  logic clk = 0, reset = 1;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [3:0] wstrb = 0;
  logic [1:0] bresp, rresp;
  logic [31:0] model [WORDS];
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  axi_lite_ram_slave #(.MEM_WORDS(WORDS), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr), .mem_axi_awprot(3'b000),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready), .mem_axi_bresp(bresp),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr), .mem_axi_arprot(3'b000),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata), .mem_axi_rresp(rresp)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  function automatic bit in_rng(input logic [31:0] a);
    return (a >> 2) < WORDS;
  endfunction
  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % WORDS);
  endfunction
  task automatic model_store(input logic [31:0] a, d, input logic [3:0] s);
    if (in_rng(a))
      for (int i = 0; i < 4; i++) if (s[i]) model[widx(a)][8*i +: 8] = d[8*i +: 8];
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic b_accept(input int b_dly, input logic [1:0] exp_resp);
    for (int k = 0; k < b_dly; k++) begin
      check("bp_awready", awready, 0);
      check("bp_wready", wready, 0);
      check("bp_bvalid", bvalid, 1);
      check("bp_bresp", bresp, exp_resp);
      tick();
    end
    bready = 1;
    tick();
    bready = 0;
    check("b_clear", bvalid, 0);
  endtask
  task automatic do_write(input logic [31:0] a, d, input logic [3:0] s, input int aw_dly, w_dly, b_dly);
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    int cyc = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid = !w_done && cyc >= w_dly;
      if (w_done && !aw_done) check("wready_held_low", wready, 0);
      if (aw_done && !w_done) check("awready_held_low", awready, 0);
      aw_f = awvalid && awready;
      w_f = wvalid && wready;
      tick();
      aw_done |= aw_f;
      w_done |= w_f;
      cyc++;
      if (!(aw_done && w_done)) check("bvalid_early", bvalid, 0);
    end
    awvalid = 0; wvalid = 0;
    check("wr_handshakes", {31'b0, aw_done && w_done}, 1);
    check("bvalid", bvalid, 1);
    check("bresp", bresp, in_rng(a) ? 2'b00 : 2'b10);
    model_store(a, d, s);
    b_accept(b_dly, in_rng(a) ? 2'b00 : 2'b10);
  endtask
  task automatic do_read(input logic [31:0] a, input int r_dly);
    logic [31:0] ed;
    logic [1:0] er;
    int cyc = 0;
    arvalid = 1; araddr = a;
    while (!arready && cyc < 20) begin tick(); cyc++; end
    check("arready", arready, 1);
    ed = in_rng(a) ? model[widx(a)] : 32'h0;
    er = in_rng(a) ? 2'b00 : 2'b10;
    tick();
    arvalid = 0;
    check("rvalid", rvalid, 1);
    check("rdata", rdata, ed);
    check("rresp", rresp, er);
    for (int k = 0; k < r_dly; k++) begin
      tick();
      check("bp_arready", arready, 0);
      check("bp_rvalid", rvalid, 1);
      check("bp_rdata", rdata, ed);
      check("bp_rresp", rresp, er);
    end
    rready = 1;
    tick();
    rready = 0;
    check("r_clear", rvalid, 0);
  endtask
  initial begin
    logic [31:0] a, d, old;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp}, 0);
    check("reset_rdata", rdata, 0);
    reset = 0;
    #1;
    check("ready_after_release", {awready, wready, arready}, 3'b111);
    tick();
    for (int i = 0; i < WORDS; i++) do_write(i * 4, $urandom, 4'hF, 0, 0, 0);
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(32'h10, 0);
    do_write(32'h20, 32'hAAAAAAAA, 4'hF, 0, 0, 0);
    do_write(32'h20, 32'h11223344, 4'b0011, 3, 0, 0);
    check("merge_model", model[8], 32'hAAAA3344);
    do_read(32'h20, 0);
    old = model[0];
    do_write(4 * WORDS, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    do_read(4 * WORDS, 0);
    do_read(32'h0, 0);
    check("oor_no_alias", model[0], old);
    do_write(32'h44, 32'h12345678, 4'hF, 1, 2, 5);
    do_read(32'h44, 5);
    do_write(32'h48, 32'h87654321, 4'h0, 0, 0, 0);
    do_read(32'h48, 0);
    old = model[4];
    awaddr = 32'h10; wdata = 32'h55555555; wstrb = 4'hF; araddr = 32'h10;
    awvalid = 1; wvalid = 1; arvalid = 1;
    check("coll_readies", {awready, wready, arready}, 3'b111);
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("coll_bvalid", bvalid, 1);
    check("coll_rvalid", rvalid, 1);
    check("coll_old_rdata", rdata, old);
    model_store(32'h10, 32'h55555555, 4'hF);
    bready = 1; rready = 1;
    tick();
    bready = 0; rready = 0;
    do_read(32'h10, 0);
    awaddr = 32'h30; awvalid = 1; araddr = 32'h20; arvalid = 1;
    tick();
    awvalid = 0; arvalid = 0;
    check("pre_reset_aw_held", awready, 0);
    check("pre_reset_rvalid", rvalid, 1);
    #2 reset = 1;
    #1;
    check("mid_reset_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp}, 0);
    check("mid_reset_rdata", rdata, 0);
    tick();
    reset = 0;
    #1;
    check("post_reset_ready", {awready, wready, arready}, 3'b111);
    wdata = 32'h0BADCAFE; wstrb = 4'hF; wvalid = 1;
    tick();
    wvalid = 0;
    for (int k = 0; k < 3; k++) begin
      check("orphan_w_no_b", bvalid, 0);
      tick();
    end
    awaddr = 32'h30; awvalid = 1;
    tick();
    awvalid = 0;
    check("late_aw_bvalid", bvalid, 1);
    model_store(32'h30, 32'h0BADCAFE, 4'hF);
    b_accept(0, 2'b00);
    do_write(32'h34, 32'hFEEDFACE, 4'hF, 0, 0, 0);
    do_read(32'h30, 0);
    do_read(32'h34, 0);
    for (int n = 0; n < 300; n++) begin
      a = $urandom_range(0, 4 * WORDS + 63);
      d = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 3));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
